univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 Parameter MSB_FIRST, default 1, serial bit order (1 = MSB first, 0 = LSB first).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_  input  1  asynchronous, active-low reset.
REQ-005 mode  input  2  operating mode: 00 PIPO, 01 SIPO, 10 PISO, 11 SISO.
REQ-006 data  input  WIDTH  parallel load word.
REQ-007 load  input  1  parallel load strobe.
REQ-008 ser_in  input  1  serial data in.
REQ-009 ser_en  input  1  shift enable; one bit moves per cycle while high.
REQ-010 out  output  WIDTH  register contents.
REQ-011 ser_out  output  1  serial data out.
REQ-012 busy  output  1  PISO word transfer or SIPO word assembly in progress.
REQ-013 done  output  1  one-cycle pulse on completion of a serial word.

Function
REQ-014 The block SHALL have two states, IDLE and SHIFT, plus a bit counter of clog2(WIDTH+1) bits.
REQ-015 The block SHALL set ser_out combinationally to the register's exit bit: bit WIDTH-1 if MSB_FIRST=1, else bit 0.
REQ-016 The block SHALL shift in at the opposite end from the exit bit.
REQ-017 In PIPO, when load=1, out SHALL equal data after the next edge (1-cycle latency); ser_en is ignored; the state stays IDLE.
REQ-018 In SIPO, each ser_en cycle SHALL shift ser_in in and increment the counter; busy=1 while the counter is in 1..WIDTH-1.
REQ-019 In SIPO, on the WIDTH-th shift the counter SHALL wrap to 0, busy SHALL fall and done SHALL pulse for one cycle.
REQ-020 In PISO IDLE, load=1 SHALL capture data, clear the counter and enter SHIFT with busy=1 on the next cycle.
REQ-021 In PISO SHIFT, each ser_en cycle SHALL shift the register one place (zero fill) and increment the counter.
REQ-022 In PISO SHIFT, after WIDTH shifts the block SHALL return to IDLE with busy=0 and pulse done.
REQ-023 In PISO SHIFT, load SHALL be ignored; no data is lost and no error is flagged.
REQ-024 In SISO, each ser_en cycle SHALL shift ser_in in, forming a WIDTH-cycle delay line; busy and done stay 0.
REQ-025 ser_en=0 SHALL hold all state in every mode.
REQ-026 load and ser_en asserted together: load SHALL win, the counter SHALL clear and no shift occurs that cycle.
REQ-027 A mode change while busy SHALL abort the transfer: IDLE, counter=0, busy=0, no done pulse, register contents retained.

Reset
REQ-028 reset_=0 SHALL immediately clear the register, counter, busy and done to 0 and select IDLE, independent of clk.
REQ-029 Reset deassertion SHALL take effect synchronously to clk; the first load is accepted on the first edge after deassertion.
REQ-030 Reset asserted during a transfer SHALL discard the transfer without a done pulse.

Configuration
REQ-031 With PARITY_EN defined, the block SHALL add output parity (1 bit) equal to the XOR of out.
REQ-032 With PARITY_EN defined, PISO SHALL transmit even parity of the captured word as bit WIDTH+1, so done follows WIDTH+1 shifts.
REQ-033 With PARITY_EN defined, SIPO SHALL also treat bit WIDTH+1 as a received parity bit and keep it in an internal flag.
REQ-034 Without PARITY_EN, the parity port and logic SHALL be absent and transfers SHALL be WIDTH bits.

Verification (WIDTH=8, MSB_FIRST=1 unless stated)
REQ-035 PIPO: data=0xA5, load=1 for one cycle -> out=0xA5 one edge later; ser_en pulses leave out unchanged.
REQ-036 PISO: load 0xC3, then ser_en held high 8 cycles -> ser_out sequence 1,1,0,0,0,0,1,1; busy high 8 cycles; single done pulse; out=0x00.
REQ-037 SIPO with MSB_FIRST=0: shift in 1,0,1,1,0,0,0,0 -> out=0x0D with done on the 8th shift; the counter then restarts at 0.
REQ-038 PISO load 0xFF, 3 shifts, then mode changed to PIPO -> busy=0 next cycle, no done pulse, out=0xF8.
REQ-039 reset_ pulled low mid-PISO between clock edges -> out=0, busy=0 immediately; a load after deassertion starts a clean 8-bit transfer.
REQ-040 PARITY_EN defined: PISO load 0x07 -> 9 serial bits 0,0,0,0,0,1,1,1,1; done after the 9th shift; parity=1 while out=0x07.

Source files
------------

// File: rtl/univ_shift_reg_if.sv
// Signal bundle for univ_shift_reg: mode/load/serial controls in, register state and status out.
// With PARITY_EN defined the bundle also carries the parity output.
interface univ_shift_reg_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       mode;
   logic [WIDTH-1:0] data;
   logic             load;
   logic             ser_in;
   logic             ser_en;
   logic [WIDTH-1:0] out;
   logic             ser_out;
   logic             busy;
   logic             done;
`ifdef PARITY_EN
   logic             parity;

   modport master (
      output mode, data, load, ser_in, ser_en,
      input  out, ser_out, busy, done, parity
   );
   modport slave (
      input  mode, data, load, ser_in, ser_en,
      output out, ser_out, busy, done, parity
   );
`else
   modport master (
      output mode, data, load, ser_in, ser_en,
      input  out, ser_out, busy, done
   );
   modport slave (
      input  mode, data, load, ser_in, ser_en,
      output out, ser_out, busy, done
   );
`endif
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register (PIPO / SIPO / PISO / SISO) with word-transfer busy/done tracking.
// Optional feature macro PARITY_EN: parity output plus a parity bit appended to serial words.
module univ_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            reset_,
   univ_shift_reg_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif

   localparam logic [1:0] M_PIPO = 2'b00;
   localparam logic [1:0] M_SIPO = 2'b01;
   localparam logic [1:0] M_PISO = 2'b10;
   localparam logic [1:0] M_SISO = 2'b11;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_reg;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_mode;
   logic             r_busy;
   logic             r_done;
   logic [CNT_W:0]   w_cnt_inc;
   logic             w_last;
   logic             w_abort;
   logic             w_load_ok;
   logic             w_exit;
`ifdef PARITY_EN
   logic             r_par_tx;
   logic             r_par_rx;
`endif

   // New bits enter at the end opposite the exit bit.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b);
      if (MSB_FIRST) return {v[WIDTH-2:0], b};
      return {b, v[WIDTH-1:1]};
   endfunction

   assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
   assign w_last    = (w_cnt_inc == (CNT_W + 1)'(NBITS));
   // r_mode holds the mode seen at the previous edge, i.e. the mode that owns a running transfer.
   assign w_abort   = r_busy && (bus.mode != r_mode);
   assign w_load_ok = bus.load && (r_state == IDLE);
   assign w_exit    = MSB_FIRST ? r_reg[WIDTH-1] : r_reg[0];

`ifdef PARITY_EN
   assign bus.ser_out = (r_state == SHIFT && r_cnt == CNT_W'(WIDTH)) ? r_par_tx : w_exit;
   assign bus.parity  = ^r_reg;
`else
   assign bus.ser_out = w_exit;
`endif
   assign bus.out  = r_reg;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_state  <= IDLE;
         r_reg    <= '0;
         r_cnt    <= '0;
         r_mode   <= M_PIPO;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef PARITY_EN
         r_par_tx <= 1'b0;
         r_par_rx <= 1'b0;
`endif
      end else begin
         r_mode <= bus.mode;
         r_done <= 1'b0;
         if (w_abort) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
         end else if (w_load_ok) begin
            r_reg <= bus.data;
            r_cnt <= '0;
            if (bus.mode == M_PISO) begin
               r_state  <= SHIFT;
               r_busy   <= 1'b1;
`ifdef PARITY_EN
               r_par_tx <= ^bus.data;
`endif
            end else begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         end else if (bus.ser_en) begin
            case (bus.mode)
               M_SIPO: begin
                  if (w_last) begin
                     r_cnt  <= '0;
                     r_busy <= 1'b0;
                     r_done <= 1'b1;
`ifdef PARITY_EN
                     r_par_rx <= bus.ser_in;
`else
                     r_reg  <= shift_in(r_reg, bus.ser_in);
`endif
                  end else begin
                     r_reg  <= shift_in(r_reg, bus.ser_in);
                     r_cnt  <= w_cnt_inc[CNT_W-1:0];
                     r_busy <= 1'b1;
                  end
               end
               M_PISO: begin
                  if (r_state == SHIFT) begin
                     r_reg <= shift_in(r_reg, 1'b0);
                     if (w_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                     end
                  end
               end
               M_SISO: r_reg <= shift_in(r_reg, bus.ser_in);
               default: r_reg <= r_reg;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: MSB-first and LSB-first instances share stimulus and are
// compared each cycle against a word/bit-sequence model, plus literal directed checks.
module tb_univ_shift_reg;
`ifdef PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int NB = 8 + int'(PAR);

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] mode;
   logic [7:0] data;
   logic       load, ser_in, ser_en;
   int         total = 0;
   int         bad = 0;
   bit         chk_en = 1'b0;

   univ_shift_reg_if #(.WIDTH(8)) bus0 ();
   univ_shift_reg_if #(.WIDTH(8)) bus1 ();

   assign bus0.mode = mode;   assign bus1.mode = mode;
   assign bus0.data = data;   assign bus1.data = data;
   assign bus0.load = load;   assign bus1.load = load;
   assign bus0.ser_in = ser_in; assign bus1.ser_in = ser_in;
   assign bus0.ser_en = ser_en; assign bus1.ser_en = ser_en;

   univ_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .reset_(rst_n), .bus(bus0));
   univ_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .reset_(rst_n), .bus(bus1));

   always #5 clk = ~clk;

   // Model: index 0 = MSB-first instance, 1 = LSB-first instance.
   logic [7:0] m_out [2];
   logic [8:0] m_seq [2];   // bits of the PISO word in transmission order
   int         m_left[2];   // PISO bits still to transmit
   int         m_rx  [2];   // SIPO bits received in the current word
   logic       m_done[2];
   logic [1:0] m_prev;

   function automatic logic [7:0] m_shift(input bit msb, input logic [7:0] v, input logic b);
      if (msb) return (v << 1) | {7'd0, b};
      return (v >> 1) | {b, 7'd0};
   endfunction

   function automatic bit m_busy(input int d);
      return (m_left[d] > 0) || (m_rx[d] > 0);
   endfunction

   function automatic logic m_ser_out(input int d);
      if (m_left[d] > 0) return m_seq[d][NB - m_left[d]];
      return (d == 0) ? m_out[d][7] : m_out[d][0];
   endfunction

   task automatic model_step();
      bit msb;
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            m_out[d] = '0; m_seq[d] = '0; m_left[d] = 0; m_rx[d] = 0; m_done[d] = 1'b0;
         end
         m_prev = 2'b00;
         return;
      end
      for (int d = 0; d < 2; d++) begin
         msb = (d == 0);
         m_done[d] = 1'b0;
         if (m_busy(d) && mode != m_prev) begin
            m_left[d] = 0;
            m_rx[d]   = 0;
         end else if (load && m_left[d] == 0) begin
            m_out[d] = data;
            m_rx[d]  = 0;
            if (mode == 2'b10) begin
               for (int i = 0; i < 8; i++) m_seq[d][i] = msb ? data[7-i] : data[i];
               m_seq[d][8] = ^data;
               m_left[d] = NB;
            end
         end else if (ser_en) begin
            case (mode)
               2'b01: begin
                  m_rx[d]++;
                  if (!(PAR && m_rx[d] == NB)) m_out[d] = m_shift(msb, m_out[d], ser_in);
                  if (m_rx[d] == NB) begin m_rx[d] = 0; m_done[d] = 1'b1; end
               end
               2'b10: if (m_left[d] > 0) begin
                  m_left[d]--;
                  m_out[d] = m_shift(msb, m_out[d], 1'b0);
                  if (m_left[d] == 0) m_done[d] = 1'b1;
               end
               2'b11: m_out[d] = m_shift(msb, m_out[d], ser_in);
               default: ;
            endcase
         end
      end
      m_prev = mode;
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input int d, input logic [7:0] o, input logic so, input logic b, input logic dn);
      check($sformatf("d%0d out", d), 32'(o), 32'(m_out[d]));
      check($sformatf("d%0d ser_out", d), 32'(so), 32'(m_ser_out(d)));
      check($sformatf("d%0d busy", d), 32'(b), 32'(m_busy(d)));
      check($sformatf("d%0d done", d), 32'(dn), 32'(m_done[d]));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp(0, bus0.out, bus0.ser_out, bus0.busy, bus0.done);
         cmp(1, bus1.out, bus1.ser_out, bus1.busy, bus1.done);
`ifdef PARITY_EN
         check("d0 parity", 32'(bus0.parity), 32'(^m_out[0]));
`endif
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [0:8] s36;
      logic [0:8] b37;
      logic [7:0] got;
      int         ndone;
      s36 = 9'b110000110;
      b37 = 9'b101100001;
      rst_n = 1'b0; mode = 2'b00; data = 8'h00; load = 1'b0; ser_in = 1'b0; ser_en = 1'b0;
      repeat (3) cyc();
      check("reset out", 32'(bus0.out), 32'h00);
      check("reset busy", 32'(bus0.busy), 32'h0);
      check("reset done", 32'(bus0.done), 32'h0);
      chk_en = 1'b1;
      #3 rst_n = 1'b1;
      cyc();

      // PIPO load, then ser_en must not disturb it
      data = 8'hA5; load = 1'b1; cyc(); load = 1'b0; data = 8'h00;
      check("pipo out", 32'(bus0.out), 32'hA5);
      check("pipo out lsb", 32'(bus1.out), 32'hA5);
      ser_en = 1'b1; ser_in = 1'b1; repeat (3) cyc(); ser_en = 1'b0;
      check("pipo hold", 32'(bus0.out), 32'hA5);

      // PISO 0xC3
      mode = 2'b10; data = 8'hC3; load = 1'b1; cyc(); load = 1'b0; ser_en = 1'b1;
      ndone = 0;
      for (int i = 0; i < NB; i++) begin
         check("piso ser_out", 32'(bus0.ser_out), 32'(s36[i]));
         check("piso ser_out lsb", 32'(bus1.ser_out), 32'(s36[i]));
         check("piso busy", 32'(bus0.busy), 32'h1);
         ndone += int'(bus0.done);
         cyc();
      end
      ser_en = 1'b0;
      check("piso early done", 32'(ndone), 32'h0);
      check("piso done", 32'(bus0.done), 32'h1);
      check("piso busy end", 32'(bus0.busy), 32'h0);
      check("piso out end", 32'(bus0.out), 32'h00);
      cyc();
      check("piso done pulse", 32'(bus0.done), 32'h0);

      // SIPO 1,0,1,1,0,0,0,0 (+ parity bit when enabled)
      mode = 2'b01; ser_en = 1'b1;
      for (int i = 0; i < NB; i++) begin
         ser_in = b37[i]; cyc();
         if (i < NB - 1) check("sipo busy", 32'(bus1.busy), 32'h1);
      end
      check("sipo out lsb", 32'(bus1.out), 32'h0D);
      check("sipo out msb", 32'(bus0.out), 32'hB0);
      check("sipo done", 32'(bus1.done), 32'h1);
      check("sipo busy end", 32'(bus1.busy), 32'h0);
      ser_in = 1'b1; cyc();
      check("sipo restart busy", 32'(bus1.busy), 32'h1);
      check("sipo restart out", 32'(bus1.out), 32'h86);
      ser_en = 1'b0; mode = 2'b00; cyc();
      check("sipo abort busy", 32'(bus1.busy), 32'h0);
      check("sipo abort keep", 32'(bus1.out), 32'h86);

      // PISO 0xFF aborted after 3 shifts
      mode = 2'b10; data = 8'hFF; load = 1'b1; cyc(); load = 1'b0;
      ser_en = 1'b1; repeat (3) cyc(); ser_en = 1'b0; mode = 2'b00; cyc();
      check("abort busy", 32'(bus0.busy), 32'h0);
      check("abort done", 32'(bus0.done), 32'h0);
      check("abort out", 32'(bus0.out), 32'hF8);
      check("abort out lsb", 32'(bus1.out), 32'h1F);

      // Asynchronous reset in the middle of a PISO transfer
      mode = 2'b10; data = 8'hA5; load = 1'b1; cyc(); load = 1'b0;
      ser_en = 1'b1; repeat (2) cyc(); ser_en = 1'b0;
      #2 rst_n = 1'b0; #1;
      check("async rst out", 32'(bus0.out), 32'h00);
      check("async rst busy", 32'(bus0.busy), 32'h0);
      check("async rst done", 32'(bus0.done), 32'h0);
      cyc();
      data = 8'h96; load = 1'b1; #3 rst_n = 1'b1; cyc(); load = 1'b0;
      check("post rst load", 32'(bus0.out), 32'h96);
      check("post rst busy", 32'(bus0.busy), 32'h1);
      ser_en = 1'b1; got = '0; ndone = 0;
      for (int i = 0; i < NB; i++) begin
         if (i < 8) got = {got[6:0], bus0.ser_out};
         ndone += int'(bus0.done);
         cyc();
      end
      ser_en = 1'b0;
      check("post rst serial", 32'(got), 32'h96);
      check("post rst early done", 32'(ndone), 32'h0);
      check("post rst done", 32'(bus0.done), 32'h1);

`ifdef PARITY_EN
      begin
         logic [8:0] g9;
         mode = 2'b10; data = 8'h07; load = 1'b1; cyc(); load = 1'b0;
         check("parity out", 32'(bus0.out), 32'h07);
         check("parity bit", 32'(bus0.parity), 32'h1);
         ser_en = 1'b1; g9 = '0;
         for (int i = 0; i < 9; i++) begin
            g9 = {g9[7:0], bus0.ser_out};
            check("parity no early done", 32'(bus0.done), 32'h0);
            cyc();
         end
         ser_en = 1'b0;
         check("parity serial", 32'(g9), 32'h00F);
         check("parity done", 32'(bus0.done), 32'h1);
      end
`endif

      // Randomized traffic, with occasional asynchronous resets
      mode = 2'b00; cyc();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         load   = ($urandom_range(0, 9) == 0);
         ser_en = ($urandom_range(0, 3) != 0);
         ser_in = 1'($urandom);
         data   = 8'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            #3 rst_n = 1'b0;
            cyc(); cyc();
            rst_n = 1'b1;
         end
         cyc();
      end
      load = 1'b0; ser_en = 1'b0;
      repeat (2) cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
